// File: rtl/reflet_uart_loader.sv
// UART boot loader: receives a length-prefixed, checksummed program image over a byte
// stream, writes it into instruction memory, and releases the CPU on success.
module reflet_uart_loader #(
   parameter int wordsize       = 8,
   parameter int addr_size      = 7,
   parameter int prog_words     = 128,
   parameter int timeout_cycles = 100000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [addr_size-1:0] mem_addr,
   output logic [wordsize-1:0]  mem_data,
   output logic                 mem_we,
   input  logic                 boot_req,
   output logic                 cpu_run,
   output logic                 busy,
   output logic                 error
);

   // state  | meaning
   // IDLE   | waiting for sync byte 0xA5, CPU held in reset
   // LEN_LO | expecting low byte of word count
   // LEN_HI | expecting high byte of word count
   // DATA   | receiving program bytes, little-endian per word
   // CHECK  | expecting checksum byte
   // REPLY  | presenting ACK (0x4B) or NAK (0x45) to the transmitter
   // RUN    | CPU released, loader dormant until boot_req

   localparam int BPW = wordsize / 8;
   localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int TW  = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   localparam int IW  = (addr_size > 16) ? addr_size : 16;
   localparam logic [TW-1:0]  TMO_LOAD   = (timeout_cycles > 0) ? TW'(timeout_cycles - 1) : '0;
   localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BPW - 1);
   localparam logic [16:0]    PROG_WORDS = 17'(prog_words);
   localparam logic [7:0]     SYNC = 8'hA5;
   localparam logic [7:0]     ACK  = 8'h4B;
   localparam logic [7:0]     NAK  = 8'h45;

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, REPLY, RUN} state_t;

   state_t state, state_nx;

   logic [15:0]         len_n;
   logic [IW-1:0]       word_idx;
   logic [BCW-1:0]      byte_cnt;
   logic [wordsize-1:0] data_sr;
   logic [wordsize-1:0] word_nx;
   logic [7:0]          sum;
   logic [TW-1:0]       tmo_cnt;
   logic [7:0]          reply_nx;
   logic [15:0]         n_word;
   logic                timing;
   logic                tmo_expire;
   logic                last_byte;
   logic                last_word;

   assign n_word     = {rx_data, len_n[7:0]};
   assign timing     = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
   // an arriving byte always beats a simultaneous expiry
   assign tmo_expire = (timeout_cycles != 0) && timing && !rx_valid && (tmo_cnt == '0);
   assign last_byte  = (byte_cnt == LAST_BYTE);
   assign last_word  = (word_idx == IW'(len_n) - IW'(1));

   assign tx_valid = (state == REPLY);
   assign cpu_run  = (state == RUN);
   assign busy     = (state != IDLE) && (state != RUN);

   always_comb begin
      word_nx = data_sr;
      word_nx[int'(byte_cnt) * 8 +: 8] = rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      reply_nx = NAK;
      case (state)
         IDLE:   if (rx_valid && rx_data == SYNC) state_nx = LEN_LO;
         LEN_LO: begin
            if (rx_valid)        state_nx = LEN_HI;
            else if (tmo_expire) state_nx = IDLE;
         end
         LEN_HI: begin
            if (rx_valid) begin
               if ({1'b0, n_word} > PROG_WORDS) state_nx = REPLY;
               else if (n_word == 16'd0)        state_nx = CHECK;
               else                             state_nx = DATA;
            end else if (tmo_expire) begin
               state_nx = IDLE;
            end
         end
         DATA: begin
            if (rx_valid && last_byte && last_word) state_nx = CHECK;
            else if (tmo_expire)                    state_nx = IDLE;
         end
         CHECK: begin
            if (rx_valid) begin
               state_nx = REPLY;
               reply_nx = (rx_data == sum) ? ACK : NAK;
            end else if (tmo_expire) begin
               state_nx = IDLE;
            end
         end
         REPLY:   if (tx_ready) state_nx = (tx_data == ACK) ? RUN : IDLE;
         RUN:     if (boot_req) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_n    <= '0;
         word_idx <= '0;
         byte_cnt <= '0;
         data_sr  <= '0;
         sum      <= '0;
         tmo_cnt  <= '0;
         error    <= 1'b0;
         tx_data  <= '0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else begin
         mem_we <= 1'b0;
         if (timing && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
         if (state_nx == REPLY && state != REPLY) tx_data <= reply_nx;
         if (tmo_expire) error <= 1'b1;
         case (state)
            IDLE: begin
               if (rx_valid && rx_data == SYNC) begin
                  error    <= 1'b0;
                  sum      <= '0;
                  len_n    <= '0;
                  word_idx <= '0;
                  byte_cnt <= '0;
                  tmo_cnt  <= TMO_LOAD;
               end
            end
            LEN_LO: begin
               if (rx_valid) begin
                  len_n[7:0] <= rx_data;
                  tmo_cnt    <= TMO_LOAD;
               end
            end
            LEN_HI: begin
               if (rx_valid) begin
                  len_n   <= n_word;
                  tmo_cnt <= TMO_LOAD;
               end
            end
            DATA: begin
               if (rx_valid) begin
                  tmo_cnt <= TMO_LOAD;
                  sum     <= sum + rx_data;
                  data_sr <= word_nx;
                  if (last_byte) begin
                     mem_we   <= 1'b1;
                     mem_addr <= word_idx[addr_size-1:0];
                     mem_data <= word_nx;
                     byte_cnt <= '0;
                     word_idx <= word_idx + 1'b1;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            CHECK:   if (rx_valid) tmo_cnt <= TMO_LOAD;
            REPLY:   if (tx_ready && tx_data != ACK) error <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reflet_uart_loader.sv
// Bench for reflet_uart_loader: an 8-bit instance with a short timeout and a 16-bit
// instance with the timeout disabled share the stimulus; a frame-level model predicts results.
module tb_reflet_uart_loader;

   localparam int PW  = 128;
   localparam int TMO = 50;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic rx_valid = 1'b0;
   logic tx_ready = 1'b0;
   logic boot_req = 1'b0;

   logic [7:0]  tx_data8, tx_data16;
   logic        tx_valid8, tx_valid16;
   logic [6:0]  mem_addr8, mem_addr16;
   logic [7:0]  mem_data8;
   logic [15:0] mem_data16;
   logic        mem_we8, mem_we16, cpu_run8, cpu_run16, busy8, busy16, error8, error16;

   always #5 clk = ~clk;

   reflet_uart_loader #(.wordsize(8), .addr_size(7), .prog_words(PW), .timeout_cycles(TMO)) u_dut8 (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready),
      .mem_addr(mem_addr8), .mem_data(mem_data8), .mem_we(mem_we8),
      .boot_req(boot_req), .cpu_run(cpu_run8), .busy(busy8), .error(error8));

   reflet_uart_loader #(.wordsize(16), .addr_size(7), .prog_words(PW), .timeout_cycles(0)) u_dut16 (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready),
      .mem_addr(mem_addr16), .mem_data(mem_data16), .mem_we(mem_we16),
      .boot_req(boot_req), .cpu_run(cpu_run16), .busy(busy16), .error(error16));

   // sel picks which instance the checks observe
   bit sel = 1'b0;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid, o_mem_we, o_cpu_run, o_busy, o_error;
   logic [6:0]  o_mem_addr;
   logic [63:0] o_mem_data;

   always_comb begin
      if (sel) begin
         o_tx_data = tx_data16; o_tx_valid = tx_valid16; o_mem_we = mem_we16;
         o_cpu_run = cpu_run16; o_busy = busy16; o_error = error16;
         o_mem_addr = mem_addr16; o_mem_data = 64'(mem_data16);
      end else begin
         o_tx_data = tx_data8; o_tx_valid = tx_valid8; o_mem_we = mem_we8;
         o_cpu_run = cpu_run8; o_busy = busy8; o_error = error8;
         o_mem_addr = mem_addr8; o_mem_data = 64'(mem_data8);
      end
   end

   logic [6:0]  cap_addr[$];
   logic [63:0] cap_data[$];
   int overlap_cnt = 0;
   bit tv_seen = 1'b0;

   always @(negedge clk) begin
      if (o_mem_we) begin
         cap_addr.push_back(o_mem_addr);
         cap_data.push_back(o_mem_data);
      end
      if (o_tx_valid) tv_seen = 1'b1;
      if ((mem_we8 && tx_valid8) || (mem_we16 && tx_valid16)) overlap_cnt++;
   end

   int n_chk = 0;
   int n_err = 0;
   bit in_run = 1'b0;
   bit last_err = 1'b0;
   logic [7:0] frame_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // caller sits on a negedge; the byte is taken at the following posedge
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      in_run = 1'b0;
      last_err = 1'b0;
      cap_addr.delete();
      cap_data.delete();
   endtask

   task automatic reply_check(input logic [7:0] exp);
      int hold;
      check("tx_valid_up", 64'(o_tx_valid), 64'd1);
      check("tx_data", 64'(o_tx_data), 64'(exp));
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
         rx_data  = 8'($urandom_range(0, 255));
         rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
         check("tx_valid_hold", 64'(o_tx_valid), 64'd1);
         check("tx_data_hold", 64'(o_tx_data), 64'(exp));
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check("tx_valid_drop", 64'(o_tx_valid), 64'd0);
      check("cpu_run_after", 64'(o_cpu_run), 64'(exp == 8'h4B));
      check("error_after", 64'(o_error), 64'(exp == 8'h45));
      check("busy_after", 64'(o_busy), 64'd0);
      in_run   = (exp == 8'h4B);
      last_err = (exp == 8'h45);
   endtask

   task automatic build_random(input int bpw, input int n, input bit corrupt);
      logic [7:0] s;
      logic [7:0] b;
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(n));
      frame_q.push_back(8'(n >> 8));
      if (n <= PW) begin
         s = 8'h00;
         for (int i = 0; i < n * bpw; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            s = s + b;
         end
         if (corrupt) s = s + 8'($urandom_range(1, 255));
         frame_q.push_back(s);
      end
   endtask

   // model: a frame is sync, 16-bit LE count, count*bpw data bytes, 8-bit sum of data bytes
   task automatic run_frame(input int bpw, input int max_gap);
      int n;
      logic [7:0] s;
      logic [7:0] exp_reply;
      logic [7:0] junk;
      logic [63:0] w;
      logic [63:0] exp_w[$];
      n = int'(frame_q[1]) + 256 * int'(frame_q[2]);
      if (in_run) begin
         boot_req = 1'b1;
         @(negedge clk);
         boot_req = 1'b0;
         check("boot_req_stop", 64'(o_cpu_run), 64'd0);
         in_run = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
         junk = 8'($urandom_range(0, 255));
         if (junk == 8'hA5) junk = 8'h00;
         send_byte(junk);
         check("idle_ignores", 64'(o_busy), 64'd0);
         check("idle_err_kept", 64'(o_error), 64'(last_err));
      end
      cap_addr.delete();
      cap_data.delete();
      send_byte(8'hA5);
      check("sync_busy", 64'(o_busy), 64'd1);
      check("sync_clears_err", 64'(o_error), 64'd0);
      tick($urandom_range(0, max_gap));
      send_byte(frame_q[1]);
      tick($urandom_range(0, max_gap));
      send_byte(frame_q[2]);
      if (n > PW) begin
         exp_reply = 8'h45;
      end else begin
         s = 8'h00;
         for (int k = 0; k < n; k++) begin
            w = 64'd0;
            for (int b = 0; b < bpw; b++) begin
               tick($urandom_range(0, max_gap));
               send_byte(frame_q[3 + k * bpw + b]);
               check("we_strobe", 64'(o_mem_we), 64'(b == bpw - 1));
               w = w | (64'(frame_q[3 + k * bpw + b]) << (8 * b));
               s = s + frame_q[3 + k * bpw + b];
            end
            exp_w.push_back(w);
         end
         tick($urandom_range(0, max_gap));
         send_byte(frame_q[3 + n * bpw]);
         exp_reply = (frame_q[3 + n * bpw] == s) ? 8'h4B : 8'h45;
      end
      reply_check(exp_reply);
      check("wr_count", 64'(cap_addr.size()), 64'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < cap_addr.size(); k++) begin
         check("wr_addr", 64'(cap_addr[k]), 64'(k));
         check("wr_data", cap_data[k], exp_w[k]);
      end
   endtask

   initial begin
      @(negedge clk);
      tick(2);
      check("rst_busy8", 64'(busy8), 64'd0);
      check("rst_run8", 64'(cpu_run8), 64'd0);
      check("rst_we8", 64'(mem_we8), 64'd0);
      check("rst_txv8", 64'(tx_valid8), 64'd0);
      check("rst_err8", 64'(error8), 64'd0);
      check("rst_addr8", 64'(mem_addr8), 64'd0);
      check("rst_data8", 64'(mem_data8), 64'd0);
      check("rst_txd8", 64'(tx_data8), 64'd0);
      check("rst_busy16", 64'(busy16), 64'd0);
      check("rst_data16", 64'(mem_data16), 64'd0);
      reset = 1'b0;
      tick(1);

      sel = 1'b0;
      frame_q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      run_frame(1, 0);
      send_byte(8'h00);
      send_byte(8'hA5);
      check("run_ignores_rx", 64'(o_cpu_run), 64'd1);
      check("run_not_busy", 64'(o_busy), 64'd0);

      frame_q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h34};
      run_frame(1, 0);
      frame_q = {8'hA5, 8'h81, 8'h00};
      run_frame(1, 2);
      frame_q = {8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame(1, 2);
      frame_q = {8'hA5, 8'h00, 8'h00, 8'h01};
      run_frame(1, 2);
      build_random(1, PW, 1'b0);
      run_frame(1, 2);
      build_random(1, $urandom_range(PW + 1, 65535), 1'b0);
      run_frame(1, 2);
      for (int it = 0; it < 6; it++) begin
         build_random(1, $urandom_range(1, 20), ($urandom_range(0, 3) == 0));
         run_frame(1, 3);
      end

      do_reset();
      tv_seen = 1'b0;
      send_byte(8'hA5);
      boot_req = 1'b1;
      @(negedge clk);
      boot_req = 1'b0;
      check("boot_ignored", 64'(o_busy), 64'd1);
      send_byte(8'h02);
      tick(TMO - 1);
      check("tmo_not_yet_busy", 64'(o_busy), 64'd1);
      check("tmo_not_yet_err", 64'(o_error), 64'd0);
      tick(1);
      check("tmo_idle", 64'(o_busy), 64'd0);
      check("tmo_err", 64'(o_error), 64'd1);
      check("tmo_no_run", 64'(o_cpu_run), 64'd0);
      check("tmo_no_reply", 64'(tv_seen), 64'd0);

      cap_addr.delete();
      cap_data.delete();
      send_byte(8'hA5);
      send_byte(8'h02);
      tick(TMO - 1);
      send_byte(8'h00);
      check("byte_wins", 64'(o_busy), 64'd1);
      send_byte(8'h5A);
      send_byte(8'hC3);
      send_byte(8'h1D);
      reply_check(8'h4B);
      check("wins_wr_count", 64'(cap_addr.size()), 64'd2);
      if (cap_data.size() == 2) begin
         check("wins_wr0", cap_data[0], 64'h5A);
         check("wins_wr1", cap_data[1], 64'hC3);
      end

      do_reset();
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h77);
      check("mid_we_up", 64'(o_mem_we), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(o_busy), 64'd0);
      check("mid_rst_we", 64'(o_mem_we), 64'd0);
      check("mid_rst_txv", 64'(o_tx_valid), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      tv_seen = 1'b0;
      send_byte(8'h10);
      send_byte(8'h20);
      tick(3);
      check("mid_rst_no_reply", 64'(tv_seen), 64'd0);
      check("mid_rst_idle", 64'(o_busy), 64'd0);

      do_reset();
      sel = 1'b1;
      tick(1);
      frame_q = {8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'h46};
      run_frame(2, 1);
      if (cap_data.size() == 1) check("w16_word", cap_data[0], 64'h1234);
      for (int it = 0; it < 4; it++) begin
         build_random(2, $urandom_range(1, 16), ($urandom_range(0, 2) == 0));
         run_frame(2, 3);
      end
      build_random(2, PW, 1'b0);
      run_frame(2, 1);

      do_reset();
      send_byte(8'hA5);
      send_byte(8'h01);
      tick(200);
      check("no_tmo_busy", 64'(o_busy), 64'd1);
      check("no_tmo_err", 64'(o_error), 64'd0);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'h55);
      send_byte(8'hFF);
      reply_check(8'h4B);

      check("we_tx_overlap", 64'(overlap_cnt), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
